// File: rtl/des_axil_ctrl.sv
// rtl/des_axil_ctrl.sv - AXI4-Lite register front-end for the DES round core
//
// Holds key and input block for the DES core, issues a one-cycle start pulse,
// captures the result and exposes busy/done status.
//
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   S_AXI_AW*/W*/B*       AXI4-Lite write address, data and response channels
//   S_AXI_AR*/R*          AXI4-Lite read address and data channels
//   core_start            single-cycle start pulse to the DES core
//   core_decrypt          0 = encrypt, 1 = decrypt
//   core_key, core_din    {KEY_HI, KEY_LO}, {DIN_HI, DIN_LO}
//   core_done, core_dout  result strobe and 64-bit result from the core
//
// Register map (word index = addr[4:2]):
//   0 CTRL (bit0 start, self-clearing; bit1 decrypt)   1 STATUS (bit0 busy, bit1 done)
//   2 KEY_LO  3 KEY_HI  4 DIN_LO  5 DIN_HI              6 DOUT_LO  7 DOUT_HI (RO)

module des_axil_ctrl #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            core_start,
  output logic                            core_decrypt,
  output logic [63:0]                     core_key,
  output logic [63:0]                     core_din,
  input  logic                            core_done,
  input  logic [63:0]                     core_dout
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state;
  logic        done;
  logic [31:0] key_lo, key_hi, din_lo, din_hi, dout_lo, dout_hi;

  logic        busy;
  logic        wr_hs, rd_hs;
  logic [2:0]  wr_idx, rd_idx;
  logic        wr_protected;
  logic        start_req;
  logic [31:0] rd_mux;

  // Byte-lane offset bits are don't-care for word registers.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign busy   = (state == RUN);
  assign wr_idx = S_AXI_AWADDR[4:2];
  assign rd_idx = S_AXI_ARADDR[4:2];

  // The ready signals are registered pulses, so a handshake is the cycle
  // in which the pulse meets the still-asserted valids.
  assign wr_hs = S_AXI_AWREADY && S_AXI_AWVALID && S_AXI_WVALID;
  assign rd_hs = S_AXI_ARREADY && S_AXI_ARVALID;

  // Operands must not change under a running core: CTRL, KEY_* and DIN_*
  // are locked while busy.
  assign wr_protected = busy && ((wr_idx == 3'd0) || (wr_idx >= 3'd2 && wr_idx <= 3'd5));
  assign start_req    = wr_hs && !busy && (wr_idx == 3'd0) && S_AXI_WSTRB[0] && S_AXI_WDATA[0];

  assign core_key    = {key_hi, key_lo};
  assign core_din    = {din_hi, din_lo};
  assign S_AXI_RRESP = 2'b00;

  function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    r = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) r[8*i +: 8] = new_val[8*i +: 8];
    end
    return r;
  endfunction

  always_comb begin
    rd_mux = 32'h0;
    case (rd_idx)
      3'd0: rd_mux = {30'h0, core_decrypt, 1'b0};
      3'd1: rd_mux = {30'h0, done, busy};
      3'd2: rd_mux = key_lo;
      3'd3: rd_mux = key_hi;
      3'd4: rd_mux = din_lo;
      3'd5: rd_mux = din_hi;
      3'd6: rd_mux = dout_lo;
      3'd7: rd_mux = dout_hi;
      default: rd_mux = 32'h0;
    endcase
  end

  // AXI handshake and response channels.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_BRESP   <= 2'b00;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= 32'h0;
    end else begin
      S_AXI_AWREADY <= S_AXI_AWVALID && S_AXI_WVALID && !S_AXI_BVALID && !S_AXI_AWREADY;
      S_AXI_WREADY  <= S_AXI_AWVALID && S_AXI_WVALID && !S_AXI_BVALID && !S_AXI_AWREADY;
      if (wr_hs) begin
        S_AXI_BVALID <= 1'b1;
        S_AXI_BRESP  <= wr_protected ? 2'b10 : 2'b00;
      end else if (S_AXI_BVALID && S_AXI_BREADY) begin
        S_AXI_BVALID <= 1'b0;
      end

      S_AXI_ARREADY <= S_AXI_ARVALID && !S_AXI_RVALID && !S_AXI_ARREADY;
      if (rd_hs) begin
        S_AXI_RVALID <= 1'b1;
        S_AXI_RDATA  <= rd_mux;
      end else if (S_AXI_RVALID && S_AXI_RREADY) begin
        S_AXI_RVALID <= 1'b0;
      end
    end
  end

  // Register file and operation FSM.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      done         <= 1'b0;
      core_start   <= 1'b0;
      core_decrypt <= 1'b0;
      key_lo       <= 32'h0;
      key_hi       <= 32'h0;
      din_lo       <= 32'h0;
      din_hi       <= 32'h0;
      dout_lo      <= 32'h0;
      dout_hi      <= 32'h0;
    end else begin
      core_start <= 1'b0;

      if (wr_hs && !wr_protected) begin
        case (wr_idx)
          3'd0: if (S_AXI_WSTRB[0]) core_decrypt <= S_AXI_WDATA[1];
          3'd2: key_lo <= apply_strb(key_lo, S_AXI_WDATA, S_AXI_WSTRB);
          3'd3: key_hi <= apply_strb(key_hi, S_AXI_WDATA, S_AXI_WSTRB);
          3'd4: din_lo <= apply_strb(din_lo, S_AXI_WDATA, S_AXI_WSTRB);
          3'd5: din_hi <= apply_strb(din_hi, S_AXI_WDATA, S_AXI_WSTRB);
          default: ;
        endcase
      end

      case (state)
        IDLE: begin
          // A start outranks a simultaneous DOUT_HI read-clear.
          if (start_req) begin
            core_start <= 1'b1;
            done       <= 1'b0;
            state      <= RUN;
          end else if (rd_hs && rd_idx == 3'd7) begin
            done <= 1'b0;
          end
        end
        RUN: begin
          if (core_done) begin
            dout_lo <= core_dout[31:0];
            dout_hi <= core_dout[63:32];
            done    <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/des_axil_ctrl.md
Name: des_axil_ctrl

Overview:
- AXI4-Lite slave register front-end for the DES encryption peripheral, sitting directly upstream of the DES round core.
- Holds the 64-bit key and 64-bit input block written by the PS master, and issues a one-cycle start to the core.
- Captures the core's 64-bit result and exposes busy/done status for polling by the master.

Parameters:
C_S_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
C_S_AXI_ADDR_WIDTH, 5, byte address width covering 8 word registers.

Ports:
clock  in  1  system clock; all logic is rising-edge.
reset  in  1  asynchronous, active-high reset.
S_AXI_AWADDR  in  5  write address.
S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  write address handshake.
S_AXI_WDATA  in  32  write data.
S_AXI_WSTRB  in  4  byte strobes.
S_AXI_WVALID / S_AXI_WREADY  in/out  1  write data handshake.
S_AXI_BRESP  out  2  write response: 00 OKAY, 10 SLVERR.
S_AXI_BVALID / S_AXI_BREADY  out/in  1  write response handshake.
S_AXI_ARADDR  in  5  read address.
S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  read address handshake.
S_AXI_RDATA  out  32  read data.
S_AXI_RRESP  out  2  read response, always 00.
S_AXI_RVALID / S_AXI_RREADY  out/in  1  read response handshake.
core_start  out  1  single-cycle start pulse to the DES core.
core_decrypt  out  1  0 = encrypt, 1 = decrypt.
core_key  out  64  {KEY_HI, KEY_LO}.
core_din  out  64  {DIN_HI, DIN_LO}.
core_done  in  1  single-cycle pulse; core_dout is valid in the same cycle.
core_dout  in  64  result block.

Behaviour:
- Register map (word-aligned; addr[1:0] ignored):
  - 0x00 CTRL: write bit0 = start (self-clearing, reads 0); bit1 = decrypt, read/write.
  - 0x04 STATUS (RO): bit0 = busy, bit1 = done.
  - 0x08 KEY_LO, 0x0C KEY_HI, 0x10 DIN_LO, 0x14 DIN_HI: read/write.
  - 0x18 DOUT_LO, 0x1C DOUT_HI: read-only.
- Reset: every output is 0, including all READY/VALID signals, BRESP, RDATA and core_start. All registers are 0; FSM state is IDLE.
- Write channel:
  - AWREADY and WREADY assert together for one cycle when AWVALID && WVALID && !BVALID.
  - The register updates on that handshake cycle, honouring WSTRB per byte.
  - BVALID asserts the next cycle and holds until BREADY.
  - At most one write is outstanding.
  - Writes to STATUS or DOUT are ignored and return OKAY.
- Read channel:
  - ARREADY pulses for one cycle when ARVALID && !RVALID.
  - RDATA is registered; RVALID asserts the next cycle and holds stable until RREADY.
  - A read of STATUS returns the value sampled in the ARREADY cycle.
- FSM states:
  - IDLE: a CTRL write with bit0 = 1 and WSTRB[0] = 1 drives core_start high for exactly the next cycle; busy = 1; done = 0; go to RUN.
  - RUN: on core_done, latch core_dout into DOUT, busy = 0, done = 1; go to IDLE.
- Busy protection: while busy, writes to CTRL, KEY_* or DIN_* are dropped (register unchanged, no start) and return BRESP = SLVERR. core_key, core_din and core_decrypt therefore stay stable for the whole operation.
- done is sticky. It clears on a new start or on a read of DOUT_HI.
- Start and a read of DOUT_HI in the same cycle: start wins and done = 0.
- A core_done arriving in IDLE is ignored.
- Simultaneous read and write handshakes are allowed; a read in the write cycle returns the pre-write value.
- Reset asserted mid-operation aborts immediately, returns to IDLE and clears DOUT. A core_done arriving after reset release is ignored.

Test Plan:
1. Reset released, then read all 8 addresses -> every RDATA = 0x00000000, RRESP = 00, core_start never high.
2. Encrypt:
   - Write KEY 0x133457799BBCDFF1 and DIN 0x0123456789ABCDEF, then CTRL = 0x1 -> core_start high for exactly 1 cycle and STATUS = 0x1.
   - Core model fires core_done with 0x85E813540F0AB405 after 16 cycles -> STATUS = 0x2, DOUT_LO = 0x0F0AB405, DOUT_HI = 0x85E81354.
   - The DOUT_HI read clears done -> STATUS then reads 0x0.
3. Busy protection:
   - While busy, write KEY_LO = 0xFFFFFFFF -> BRESP = 10, KEY_LO still 0x9BBCDFF1.
   - Write CTRL = 0x1 while busy -> no second core_start.
4. Byte strobes: write DIN_LO = 0xAABBCCDD with WSTRB = 0101 over value 0 -> readback 0x00BB00DD.
5. Backpressure:
   - Hold BREADY low for 5 cycles -> BVALID stays high, no AWREADY for a second write.
   - Hold RREADY low -> RDATA stays stable.
6. Reset mid-RUN: assert reset 3 cycles after start -> STATUS = 0, DOUT = 0; a later core_done pulse leaves STATUS = 0.
